// File: rtl/ws2812_fancy_fader.sv
// ws2812_fancy_fader: per-byte random-target fading pattern source for a WS2812 serialiser
module ws2812_fancy_fader #(
   parameter int NUM_LEDS     = 8,
   parameter int HOLDOFF_TIME = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] random,
   input  logic        data_request,
   output logic        trigger,
   output logic [7:0]  color_now
);
   localparam int FRAME_BYTES = NUM_LEDS * 3;
   localparam int IW = $clog2(FRAME_BYTES);
   localparam int CW = $clog2(HOLDOFF_TIME + 1);
   typedef enum logic [1:0] {HOLDOFF, TRIG, STREAM} state_t;
   state_t        state;
   logic [CW-1:0] counter;
   logic [IW-1:0] idx;
   logic [7:0]    level  [FRAME_BYTES];
   logic [7:0]    target [FRAME_BYTES];
   logic          unused_random;
   assign unused_random = ^random[15:8];
   // byte on offer: streamed byte during a frame, byte 0 otherwise
   assign color_now = (state == STREAM) ? level[idx] : level[0];
   // frame sequencer plus per-byte fade toward target, target reload on arrival
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= HOLDOFF;
         counter <= CW'(HOLDOFF_TIME);
         idx     <= '0;
         trigger <= 1'b0;
         for (int i = 0; i < FRAME_BYTES; i++) begin
            level[i]  <= '0;
            target[i] <= '0;
         end
      end else begin
         case (state)
            HOLDOFF: begin
               if (counter == '0) begin
                  state   <= TRIG;
                  trigger <= 1'b1;
               end else
                  counter <= counter - 1'b1;
            end
            TRIG: begin
               trigger <= 1'b0;
               idx     <= '0;
               state   <= STREAM;
            end
            default: begin
               if (data_request) begin
                  if (level[idx] < target[idx])
                     level[idx] <= level[idx] + 8'd1;
                  else if (level[idx] > target[idx])
                     level[idx] <= level[idx] - 8'd1;
                  else
                     target[idx] <= random[7:0];
                  if (idx == IW'(FRAME_BYTES - 1)) begin
                     idx     <= '0;
                     counter <= CW'(HOLDOFF_TIME);
                     state   <= HOLDOFF;
                  end else
                     idx <= idx + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_fancy_fader.sv
// tb_ws2812_fancy_fader: directed checks of frame timing, fading and reset behaviour
module tb_ws2812_fancy_fader;
   localparam int H  = 4;
   localparam int FB = 24;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dr  = 1'b0;
   logic [15:0] random = '0;
   logic        trigger;
   logic [7:0]  color_now;
   int          checks = 0;
   int          failures = 0;

   ws2812_fancy_fader #(.NUM_LEDS(8), .HOLDOFF_TIME(H)) dut (
      .clk(clk), .rst(rst), .random(random), .data_request(dr),
      .trigger(trigger), .color_now(color_now)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_trig(input string tag, input int exp_n);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 50) begin
         step;
         n++;
         seen = trigger;
      end
      check(tag, seen ? n : -1, exp_n);
   endtask

   task automatic frame(input string tag, input int gap, input logic [7:0] e_even, input logic [7:0] e_odd,
                        input logic [15:0] r_even, input logic [15:0] r_odd);
      bit trig_seen = 0;
      step;
      dr = 1'b0;
      for (int i = 0; i < FB; i++) begin
         check(tag, color_now, (i % 2) ? e_odd : e_even);
         random = (i % 2) ? r_odd : r_even;
         dr = 1'b1;
         step;
         trig_seen |= trigger;
         dr = 1'b0;
         if (i < FB - 1)
            repeat (gap) begin
               step;
               trig_seen |= trigger;
            end
      end
      check({tag, "_no_trig"}, trig_seen, 0);
      wait_trig({tag, "_gap"}, H + 1);
   endtask

   initial begin
      rst = 1'b0;
      dr = 1'b1;
      random = 16'hFFFF;
      repeat (3) step;
      check("rst_trigger", trigger, 0);
      check("rst_color", color_now, 0);
      rst = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step;
         check("first_trigger", trigger, c == 5);
         check("holdoff_color", color_now, 0);
      end
      frame("f0", 3, 8'h00, 8'h00, 16'hAAAA, 16'hAAAA);
      for (int k = 1; k <= 172; k++) begin
         int e;
         e = (k <= 171) ? k - 1 : 8'hAA;
         frame("fade_up", 0, 8'(e), 8'(e), 16'hAAAA, 16'hAAAA);
      end
      frame("reload_10", 0, 8'hAA, 8'hAA, 16'h0010, 16'h0010);
      for (int f = 174; f <= 330; f++) begin
         int e;
         e = (170 - (f - 174) > 16) ? 170 - (f - 174) : 16;
         frame("fade_down", 0, 8'(e), 8'(e), 16'h0010, 16'h0010);
      end
      step;
      dr = 1'b1;
      repeat (10) step;
      dr = 1'b0;
      check("pre_reset_color", color_now, 8'h10);
      #3 rst = 1'b0;
      #1;
      check("async_trigger", trigger, 0);
      check("async_color", color_now, 0);
      rst = 1'b1;
      wait_trig("rst_retrig", H + 1);
      dr = 1'b1;
      frame("r0", 0, 8'h00, 8'h00, 16'h0000, 16'h0005);
      frame("r1", 0, 8'h00, 8'h00, 16'h0000, 16'h0000);
      frame("r2_alt", 0, 8'h00, 8'h01, 16'h0000, 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
